// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the CPU clock-enable sequencer.
// Imported by the step controller and its button conditioner.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } cpuStateT;

    localparam int RateShift = 2;
    localparam int StepCntW  = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debounce, press pulse.
// Press is a one-cycle pulse on the debounced 0->1 transition.
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DebVal = 1000000,
    parameter int CntW   = 26
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnRaw,
    output logic Press
);

    logic sync1;
    logic sync2;
    logic btnD;
    logic btnPrev;
    logic [CntW-1:0] debCnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= BtnRaw;
            sync2 <= sync1;
        end
    end

    // Flip on the DebVal-th consecutive cycle the synced level disagrees.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            btnD   <= 1'b0;
            debCnt <= '0;
        end else if (sync2 == btnD) begin
            debCnt <= '0;
        end else if (debCnt >= CntW'(DebVal - 1)) begin
            btnD   <= sync2;
            debCnt <= '0;
        end else begin
            debCnt <= debCnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            btnPrev <= 1'b0;
        end else begin
            btnPrev <= btnD;
        end
    end

    assign Press = btnD & ~btnPrev;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Single-cycle CPU enable sequencer: free-run divider, single-step, breakpoint halt.
// CpuEn is a registered one-cycle pulse on the board clock.
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DivVal = 10000,
    parameter int DebVal = 1000000,
    parameter int CntW   = 26
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                RunSw,
    input  logic                StepBtn,
    input  logic [1:0]          RateSel,
    input  logic                Brk,
    output logic                CpuEn,
    output logic                Halted,
    output logic [StepCntW-1:0] StepCnt
);

    localparam logic [CntW-1:0] DivBase = CntW'(DivVal);

    cpuStateT        state;
    cpuStateT        stateNext;
    logic            runMeta;
    logic            runS;
    logic            runPrev;
    logic            runReq;
    logic            stepReq;
    logic            cpuEnNext;
    logic [CntW-1:0] divCnt;
    logic [CntW-1:0] divNext;
    logic [CntW-1:0] termRaw;
    logic [CntW-1:0] term;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            runMeta <= 1'b0;
            runS    <= 1'b0;
            runPrev <= 1'b0;
        end else begin
            runMeta <= RunSw;
            runS    <= runMeta;
            runPrev <= runS;
        end
    end

    // Only a fresh rising edge starts a run; a held switch cannot resume.
    assign runReq = runS & ~runPrev;

    btn_debounce #(
        .DebVal(DebVal),
        .CntW  (CntW)
    ) uStepDeb (
        .Clk   (Clk),
        .Rst   (Rst),
        .BtnRaw(StepBtn),
        .Press (stepReq)
    );

    always_comb begin
        termRaw = DivBase >> (RateShift * int'(RateSel));
        term    = (termRaw == '0) ? CntW'(1) : termRaw;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= HALT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            HALT: begin
                if (runReq) begin
                    stateNext = RUN;
                end else if (stepReq) begin
                    stateNext = STEP;
                end
            end
            RUN: begin
                if (!runS || Brk) begin
                    stateNext = HALT;
                end
            end
            STEP: stateNext = HALT;
            default: stateNext = HALT;
        endcase
    end

    // >= rather than == so a rate change mid-count cannot overrun the divider.
    always_comb begin
        cpuEnNext = 1'b0;
        divNext   = '0;
        unique case (state)
            RUN: begin
                if (!runS || Brk) begin
                    divNext = '0;
                end else if (divCnt >= term) begin
                    cpuEnNext = 1'b1;
                end else begin
                    divNext = divCnt + 1'b1;
                end
            end
            STEP: cpuEnNext = 1'b1;
            default: begin
                cpuEnNext = 1'b0;
                divNext   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            divCnt <= '0;
            CpuEn  <= 1'b0;
            Halted <= 1'b1;
        end else begin
            divCnt <= divNext;
            CpuEn  <= cpuEnNext;
            Halted <= (stateNext != RUN);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            StepCnt <= '0;
        end else if (CpuEn) begin
            StepCnt <= StepCnt + 1'b1;
        end
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Clock-enable sequencer for the MIPS processor on the board. It replaces free-running divided clocks with a single-cycle enable, `CpuEn`, on the 100 MHz board clock. The processor can free-run at a selectable divided rate, single-step from a push button, or halt on a breakpoint. It sits between the board I/O (switches, button) and the processor pipeline's global enable.

## Interface
**Parameters**
- `DivVal`, default 10000: base terminal count for run mode. The run-mode period at `RateSel`=0 is `DivVal`+1 cycles.
- `DebVal`, default 1000000: number of consecutive stable cycles required to accept a new button level.
- `CntW`, default 26: width of the divider and debounce counters.

**Ports**
- `Clk`  in  1  board clock; all logic on its rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `RunSw`  in  1  raw slide switch; 1 = run request.
- `StepBtn`  in  1  raw push button; 1 = pressed.
- `RateSel`  in  2  run-rate select; terminal count `Term` = max(`DivVal` >> (2·`RateSel`), 1).
- `Brk`  in  1  breakpoint hit from the processor, level.
- `CpuEn`  out  1  registered, one-`Clk`-cycle processor enable pulse.
- `Halted`  out  1  registered; 1 in the HALT state.
- `StepCnt`  out  32  count of `CpuEn` pulses issued; wraps modulo 2^32.

## Operation
- **`RunSw` conditioning:** 2-FF synchronizer, reset value 0, giving `RunS`. A run request is a rising edge of `RunS` (registered previous value, also reset to 0).
- **`StepBtn` conditioning:** 2-FF synchronizer, then debounce.
  - The debounced level `BtnD` (reset 0) flips only after the synced input differs from `BtnD` for `DebVal` consecutive cycles.
  - Any cycle where the synced input equals `BtnD` clears the debounce counter.
  - A step request is a single-cycle pulse on the `BtnD` 0→1 transition.
- **FSM states:** HALT (reset state), RUN, STEP.
- **HALT:**
  - A run request moves to RUN.
  - Otherwise, a step request moves to STEP. Stepping is allowed while `Brk`=1, so the processor can step past a breakpoint.
  - `DivCnt` is held at 0.
- **RUN** (priority in this order):
  1. `RunS`=0 or `Brk`=1: go to HALT, clear `DivCnt`, no pulse.
  2. `DivCnt` >= `Term`: `CpuEn`=1 next cycle, `DivCnt` ← 0.
  3. Otherwise: `DivCnt` ← `DivCnt`+1.
- Step requests are ignored in RUN.
- **Changing `RateSel` mid-run:** the `>=` compare ends an over-long count on the next cycle. There is no lockup.
- **STEP:** issue exactly one `CpuEn` pulse, then return to HALT. Requests arriving during STEP are dropped.
- **`StepCnt`:** increments on every cycle where `CpuEn`=1.
- **`Halted`:** 1 in HALT and STEP; 0 in RUN.
- **Resuming after a breakpoint or switch halt:** `RunSw` must go low and then high again. A level-high `RunSw` never re-enters RUN.

## Timing
- **Reset values** (asynchronous, immediate, including mid-pulse or mid-debounce): `CpuEn`=0, `Halted`=1, `StepCnt`=0, state HALT, `DivCnt`=0, `BtnD`=0, all synchronizer flops 0.
- **Run entry:** RUN is entered 3 cycles after `RunSw` rises (2 sync + 1 edge register).
- **Run pulses:** the first `CpuEn` comes `Term`+1 cycles after RUN entry. Subsequent pulses are spaced exactly `Term`+1 cycles apart.
- **Halt latency:** `Brk` or `RunS` low stops pulses from the next cycle on. A pulse already registered in the same cycle still completes.
- **Step latency:** `CpuEn` follows a stable press by 2 sync + `DebVal` + 1 edge + 1 FSM cycles.
- **Pulse width:** `CpuEn` is never high for two consecutive cycles unless `Term`=0, which cannot occur because `Term` is clamped to a minimum of 1.

## Structure
- **Package `cpu_clk_pkg`:** state enum (HALT, RUN, STEP), `RateSel` shift constant (2), and the `StepCnt` width constant (32).
- **Sub-module `btn_debounce`:** synchronizer, debounce counter, and rising-edge pulse. It is parameterized by `DebVal`/`CntW` and reused for future board buttons.
- **Top module:** contains the FSM, the divider, and `StepCnt`.

## Test plan
All scenarios use `DivVal`=7 and `DebVal`=4.
- **Reset then run:** hold `Rst`=0 with `RunSw`=1 and `RateSel`=0, then release. Required: `Halted`=1 during reset; RUN entered 3 cycles after release; `CpuEn` pulses every 8 cycles; `StepCnt` reaches 3 after 3 pulses.
- **Rate change:** in RUN, set `RateSel`=1 (`Term`=1). Required: pulse spacing becomes 2 cycles within one period. `RateSel`=3 gives `Term`=1 (clamped).
- **Breakpoint:** raise `Brk` for 1 cycle in RUN. Required: `Halted`=1 next cycle and no further pulses while `RunSw` stays 1. `RunSw` 1→0→1 resumes RUN.
- **Bouncing step:** with `RunSw`=0, toggle `StepBtn` for 3 cycles, then hold it high for 20 cycles. Required: exactly one `CpuEn`, `StepCnt` +1, `Halted` remains 1. Release and re-press gives exactly one more pulse.
- **Short glitch:** drive `StepBtn` high for 3 cycles in HALT. Required: no `CpuEn`.
- **Mid-operation reset:** assert `Rst`=0 mid-run on the cycle `CpuEn`=1. Required: `CpuEn`=0, `StepCnt`=0, `Halted`=1 immediately, without waiting for a clock edge.
